mem_bank_arbiter: RTL
=====================

Name: mem_bank_arbiter

Overview:
- Round-robin arbiter sharing one mem_bank (single-cycle, byte-strobed, synchronous read) between NumReq requesters.
- Each requester has a valid/ready request channel and a response strobe.
- The winner's request is forwarded to the bank in the grant cycle.
- Read data is routed back one cycle later with a one-hot response valid.

Parameters:
- AddrWidth, 8, bank byte-address width.
- DataSize, 2, log2 of bytes per word; DataBytes = 2**DataSize, DataWidth = 8*DataBytes.
- NumReq, 2, number of requesters (>=2).

Ports:
- clk_i  in  1  clock
- arst_ni  in  1  asynchronous active-low reset
- req_valid_i  in  NumReq  per-requester request valid
- req_ready_o  out  NumReq  per-requester grant/accept (one-hot or zero)
- req_addr_i  in  NumReq*AddrWidth  packed addresses, requester k at [k*AddrWidth +: AddrWidth]
- req_wdata_i  in  NumReq*DataWidth  packed write data
- req_wstrb_i  in  NumReq*DataBytes  packed byte strobes; all-zero = read
- rsp_valid_o  out  NumReq  one-hot response valid
- rsp_rdata_o  out  DataWidth  response data, shared by all requesters
- mem_cs_o  out  1  bank chip select
- mem_addr_o  out  AddrWidth  bank address
- mem_wdata_o  out  DataWidth  bank write data
- mem_wstrb_o  out  DataBytes  bank strobes
- mem_rdata_i  in  DataWidth  bank read data, valid the cycle after cs

Behaviour:
- Clock and reset: one clock, clk_i. Reset is asynchronous and active-low on arst_ni.
- Reset values: rsp_valid_o=0, rr pointer=0, lock owner cleared.
  - While arst_ni=0: mem_cs_o=0, req_ready_o=0.
- Arbitration (combinational, same cycle):
  - Among asserted req_valid_i, grant the first index at or after the rr pointer, wrapping modulo NumReq.
  - req_ready_o is one-hot on the winner; zero if no valid request.
- Transfer: happens when req_valid_i[k] & req_ready_o[k]. In that cycle:
  - mem_cs_o=1.
  - mem_addr_o/wdata_o/wstrb_o = requester k's fields.
  - Otherwise mem_cs_o=0 and mem_* data outputs are 0.
- Pointer: on a transfer to k, pointer <= (k+1) mod NumReq; unchanged when idle.
- Response: cycle after a transfer to k:
  - rsp_valid_o = one-hot k; rsp_rdata_o = mem_rdata_i.
  - This cycle is the bank read of the addressed word after the strobed write is merged.
  - rsp_rdata_o passes mem_rdata_i combinationally.
  - rsp_valid_o is registered.
- Throughput: one transfer per cycle, back-to-back. Latency 1 cycle request-to-response.
- No response back-pressure; requesters must accept rsp_valid_o unconditionally.
- Requesters hold valid and fields stable until ready; the arbiter does not check this.
- Address: passed unmodified. Byte-lane wrap past 2**AddrWidth-1 is the bank's behaviour.
- All NumReq valid continuously: strict rotation 0,1,…,NumReq-1,0.
- Reset mid-operation: an in-flight response is dropped (rsp_valid_o=0 immediately) and the pointer returns to 0.

Optional Feature:
- Macro: MEM_BANK_ARBITER_LOCK_EN.
- Defined:
  - Adds port req_lock_i (in, NumReq).
  - Lock owner register (valid + index) is set on a transfer whose req_lock_i[k]=1.
  - While the lock is valid, only the owner is eligible; others stall with ready=0.
  - The lock is cleared by the owner's transfer with req_lock_i=0, or by reset.
  - Pointer updates as normal on each transfer.
- Undefined: port absent; pure round-robin.

Decomposition:
- Package mem_bank_pkg: default constants DefAddrWidth=8, DefDataSize=2.
- One sub-module, rr_arbiter, parameterised on NumReq:
  - Inputs: request vector and pointer.
  - Outputs: one-hot grant and grant index.
- Muxing, pointer, response register and lock logic stay in mem_bank_arbiter.

Test Plan:
1. Reset: drive arst_ni=0 with req_valid_i=11 → mem_cs_o=0, req_ready_o=00, rsp_valid_o=00. Release, then pointer at 0: first grant goes to req0.
2. Write/read: req0 writes addr 0x10, wdata 0xDEADBEEF, wstrb 1111 → ready=01, mem_cs_o=1 that cycle, next cycle rsp_valid=01, rdata=0xDEADBEEF. Then req0 reads 0x10 with wstrb 0000 → rdata=0xDEADBEEF.
3. Contention: req_valid_i=11 held for 6 cycles → grants 0,1,0,1,0,1. rsp_valid_o follows one cycle later with matching one-hot.
4. Partial strobe: addr 0x20 preloaded with 0x11223344. req1 writes 0xAABBCCDD with wstrb 1010 → rsp rdata=0xAA22CC44, rsp_valid=10.
5. Reset mid-transfer: transfer to req1, then arst_ni=0 before the next edge → rsp_valid_o=00. After release, req_valid_i=11 grants req0 first.
6. Lock (MEM_BANK_ARBITER_LOCK_EN defined): req0 makes 3 transfers with lock=1,1,0 while req1 is valid throughout → grants 0,0,0, then 1.

Source files
------------

// File: rtl/mem_bank_pkg.sv
// Shared defaults for the mem_bank arbiter slice and an index-width helper.
package mem_bank_pkg;

    localparam int unsigned DefAddrWidth = 8;
    localparam int unsigned DefDataSize  = 2;
    localparam int unsigned DefNumReq    = 2;

    // Width of a requester index; never zero so single-bit ports stay legal.
    function automatic int unsigned idx_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin picker: first asserted request at or after ptr_i, wrapping.
// Pure combinational; the caller owns the pointer register.
module rr_arbiter
    import mem_bank_pkg::*;
#(
    parameter  int unsigned NumReq = DefNumReq,
    localparam int unsigned IdxW   = idx_width(NumReq)
) (
    input  logic [NumReq-1:0] req_i,
    input  logic [IdxW-1:0]   ptr_i,
    output logic [NumReq-1:0] gnt_o,
    output logic [IdxW-1:0]   idx_o
);

    logic [NumReq-1:0] upper;
    logic [NumReq-1:0] sel;

    // Requests at or above the pointer win first; otherwise wrap to the bottom.
    for (genvar gi = 0; gi < NumReq; gi++) begin : g_upper
        assign upper[gi] = req_i[gi] & (IdxW'(gi) >= ptr_i);
    end

    assign sel = (|upper) ? upper : req_i;

    always_comb begin
        idx_o = '0;
        for (int i = int'(NumReq) - 1; i >= 0; i--) begin
            if (sel[i]) begin
                idx_o = IdxW'(i);
            end
        end
    end

    for (genvar gi = 0; gi < NumReq; gi++) begin : g_gnt
        assign gnt_o[gi] = sel[gi] & (idx_o == IdxW'(gi));
    end

endmodule

// File: rtl/mem_bank_arbiter.sv
// Round-robin sharing of one single-cycle mem_bank between NumReq requesters.
// Optional owner lock is enabled by defining MEM_BANK_ARBITER_LOCK_EN.
module mem_bank_arbiter
    import mem_bank_pkg::*;
#(
    parameter  int unsigned AddrWidth = DefAddrWidth,
    parameter  int unsigned DataSize  = DefDataSize,
    parameter  int unsigned NumReq    = DefNumReq,
    localparam int unsigned DataBytes = 1 << DataSize,
    localparam int unsigned DataWidth = 8 * DataBytes,
    localparam int unsigned IdxW      = idx_width(NumReq)
) (
    input  logic                           clk_i,
    input  logic                           arst_ni,
    input  logic [NumReq-1:0]              req_valid_i,
    output logic [NumReq-1:0]              req_ready_o,
    input  logic [NumReq*AddrWidth-1:0]    req_addr_i,
    input  logic [NumReq*DataWidth-1:0]    req_wdata_i,
    input  logic [NumReq*DataBytes-1:0]    req_wstrb_i,
`ifdef MEM_BANK_ARBITER_LOCK_EN
    input  logic [NumReq-1:0]              req_lock_i,
`endif
    output logic [NumReq-1:0]              rsp_valid_o,
    output logic [DataWidth-1:0]           rsp_rdata_o,
    output logic                           mem_cs_o,
    output logic [AddrWidth-1:0]           mem_addr_o,
    output logic [DataWidth-1:0]           mem_wdata_o,
    output logic [DataBytes-1:0]           mem_wstrb_o,
    input  logic [DataWidth-1:0]           mem_rdata_i
);

    logic [IdxW-1:0]      ptr_q, ptr_d;
    logic [NumReq-1:0]    rsp_valid_q, rsp_valid_d;
    logic [NumReq-1:0]    eligible;
    logic [NumReq-1:0]    gnt;
    logic [IdxW-1:0]      gnt_idx;
    logic                 xfer;

    logic [AddrWidth-1:0] addr_arr  [NumReq];
    logic [DataWidth-1:0] wdata_arr [NumReq];
    logic [DataBytes-1:0] wstrb_arr [NumReq];

    for (genvar gi = 0; gi < NumReq; gi++) begin : g_unpack
        assign addr_arr[gi]  = req_addr_i[gi*AddrWidth +: AddrWidth];
        assign wdata_arr[gi] = req_wdata_i[gi*DataWidth +: DataWidth];
        assign wstrb_arr[gi] = req_wstrb_i[gi*DataBytes +: DataBytes];
    end

`ifdef MEM_BANK_ARBITER_LOCK_EN
    logic              lock_valid_q, lock_valid_d;
    logic [IdxW-1:0]   lock_owner_q, lock_owner_d;
    logic [NumReq-1:0] owner_mask;

    for (genvar gi = 0; gi < NumReq; gi++) begin : g_owner
        assign owner_mask[gi] = (lock_owner_q == IdxW'(gi));
    end

    assign eligible = lock_valid_q ? (req_valid_i & owner_mask) : req_valid_i;

    // Every transfer re-decides the lock from its own lock bit; while locked
    // only the owner can transfer, so a lock=0 transfer is the release.
    always_comb begin
        lock_valid_d = lock_valid_q;
        lock_owner_d = lock_owner_q;
        if (xfer) begin
            lock_valid_d = req_lock_i[gnt_idx];
            lock_owner_d = gnt_idx;
        end
    end

    always_ff @(posedge clk_i or negedge arst_ni) begin
        if (!arst_ni) begin
            lock_valid_q <= 1'b0;
            lock_owner_q <= '0;
        end else begin
            lock_valid_q <= lock_valid_d;
            lock_owner_q <= lock_owner_d;
        end
    end
`else
    assign eligible = req_valid_i;
`endif

    rr_arbiter #(
        .NumReq (NumReq)
    ) u_rr_arbiter (
        .req_i  (eligible),
        .ptr_i  (ptr_q),
        .gnt_o  (gnt),
        .idx_o  (gnt_idx)
    );

    // Grants are suppressed while reset is held so nothing reaches the bank.
    assign req_ready_o = arst_ni ? gnt : '0;
    assign xfer        = |(req_valid_i & req_ready_o);

    always_comb begin
        mem_cs_o    = xfer;
        mem_addr_o  = '0;
        mem_wdata_o = '0;
        mem_wstrb_o = '0;
        if (xfer) begin
            mem_addr_o  = addr_arr[gnt_idx];
            mem_wdata_o = wdata_arr[gnt_idx];
            mem_wstrb_o = wstrb_arr[gnt_idx];
        end
    end

    always_comb begin
        ptr_d       = ptr_q;
        rsp_valid_d = xfer ? req_ready_o : '0;
        if (xfer) begin
            ptr_d = (gnt_idx == IdxW'(NumReq - 1)) ? '0 : gnt_idx + 1'b1;
        end
    end

    always_ff @(posedge clk_i or negedge arst_ni) begin
        if (!arst_ni) begin
            ptr_q       <= '0;
            rsp_valid_q <= '0;
        end else begin
            ptr_q       <= ptr_d;
            rsp_valid_q <= rsp_valid_d;
        end
    end

    assign rsp_valid_o = rsp_valid_q;
    // The bank returns read data one cycle after cs, aligned with rsp_valid_q.
    assign rsp_rdata_o = mem_rdata_i;

endmodule
